iob_uart_poller: RTL and testbench
==================================

IOB_UART_POLLER -- requirements
Module: iob_uart_poller

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, native-bus word-address width of the UART register bank.
REQ-002 SHALL have parameter DATA_W, default 32, native-bus data width.
REQ-003 SHALL have parameter BAUD_DIV, default 16'd100, divisor value written during init.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries per RX/TX byte buffer (power of 2, at least 2).
REQ-005 SHALL have ports in this order:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- iob_valid_o  output  1  bus request.
- iob_addr_o  output  ADDR_W  UART register address.
- iob_wdata_o  output  DATA_W  write data.
- iob_wstrb_o  output  DATA_W/8  byte strobes (0 = read).
- iob_rdata_i  input  DATA_W  read data, valid while iob_ready_i=1.
- iob_ready_i  input  1  transfer complete.
- rx_data_o  output  8  received byte.
- rx_valid_o  output  1  rx_data_o valid.
- rx_ready_i  input  1  consumer accepts byte.
- tx_data_i  input  8  byte to transmit.
- tx_valid_i  input  1  tx_data_i valid.
- tx_ready_o  output  1  TX buffer can accept.
- init_done_o  output  1  UART configured.

Function
REQ-006 Bus handshake SHALL be: iob_valid_o and iob_addr_o/iob_wdata_o/iob_wstrb_o held constant from issue until the cycle iob_ready_i=1; iob_valid_o SHALL deassert the following cycle, with at most one outstanding transfer.
REQ-007 FSM states SHALL be INIT_DIV, INIT_TXEN, INIT_RXEN, POLL_RX, READ_RX, POLL_TX, WRITE_TX.
REQ-008 INIT_DIV SHALL write BAUD_DIV to DIV_ADDR with wstrb 4'b0011; INIT_TXEN SHALL write 1 to TXEN_ADDR with wstrb 4'b0001; INIT_RXEN SHALL write 1 to RXEN_ADDR with wstrb 4'b0001; each SHALL advance on iob_ready_i.
REQ-009 init_done_o SHALL rise in the cycle after INIT_RXEN completes and stay high until reset.
REQ-010 POLL_RX SHALL read RXREADY_ADDR; on completion it SHALL go to READ_RX if iob_rdata_i[0]=1 and the RX FIFO is not full, and to POLL_TX otherwise.
REQ-011 READ_RX SHALL read RXDATA_ADDR, push iob_rdata_i[7:0] into the RX FIFO in the completion cycle, then go to POLL_TX.
REQ-012 POLL_TX SHALL go directly to POLL_RX, with no bus transfer, when the TX FIFO is empty; otherwise it SHALL read TXREADY_ADDR and go to WRITE_TX if iob_rdata_i[0]=1, else to POLL_RX.
REQ-013 WRITE_TX SHALL write the TX FIFO head to TXDATA_ADDR (wdata[7:0]=byte, upper bits 0, wstrb 4'b0001), pop it in the completion cycle, then go to POLL_RX.
REQ-014 RX and TX polls SHALL strictly alternate so neither direction starves.
REQ-015 The RX FIFO SHALL drive rx_valid_o=~empty; pop SHALL occur on rx_valid_o&rx_ready_i; a push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-016 The TX FIFO SHALL drive tx_ready_o=~full; push SHALL occur on tx_valid_i&tx_ready_o; a simultaneous push and pop SHALL both take effect.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a count of width log2(FIFO_DEPTH)+1.
REQ-018 tx_ready_o SHALL be 0 until init_done_o=1; TX bytes SHALL NOT be accepted before then.
REQ-019 No byte SHALL be dropped or duplicated, and bytes SHALL be delivered in order in both directions.

Reset
REQ-020 On reset=1 at a clock edge, the FSM SHALL enter INIT_DIV, both FIFOs SHALL empty, and iob_valid_o, iob_wstrb_o, rx_valid_o, tx_ready_o and init_done_o SHALL be 0; iob_addr_o and iob_wdata_o SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer without waiting for iob_ready_i; the block SHALL restart init in the cycle after reset deasserts.

Structure
REQ-022 Register address constants (DIV_ADDR, TXEN_ADDR, RXEN_ADDR, TXDATA_ADDR, RXDATA_ADDR, TXREADY_ADDR, RXREADY_ADDR), matching the UART swreg map, and the FSM state encoding SHALL live in shared package iob_uart_poller_pkg.
REQ-023 Both buffers SHALL be instances of one sub-module, iob_uart_poller_fifo (8-bit wide, FIFO_DEPTH entries).

Verification
REQ-024 Reset release, bus slave ready after 2 cycles -> exactly three writes in order: DIV=0x0064 (wstrb 0011), TXEN=1, RXEN=1; init_done_o=1 one cycle after the third ready.
REQ-025 Slave returns RXREADY=1 and RXDATA=0x41 then 0x42, with rx_ready_i=1 -> rx_data_o shows 0x41 then 0x42, each for one valid cycle.
REQ-026 Push 0x55,0xAA with TXREADY=1 -> two TXDATA writes with wdata 0x00000055 then 0x000000AA, wstrb 0001.
REQ-027 rx_ready_i=0 with RXREADY always 1 -> 4 bytes buffered, after which no RXDATA reads occur and only RXREADY polls continue; raising rx_ready_i drains the bytes in order.
REQ-028 TXREADY=0 for 50 cycles with 4 bytes queued -> tx_ready_o=0 and no TXDATA writes; when TXREADY becomes 1, the 4 bytes are written in order.
REQ-029 Reset asserted while iob_valid_o=1 and iob_ready_i held low -> iob_valid_o=0 the next cycle, FIFOs empty, and init restarts with a DIV write.

Source files
------------

// File: rtl/iob_uart_poller_pkg.sv
// Shared UART register map, poller state encoding and FIFO sizing helper.
// Pure definitions: no logic, no latency, no flow control.
package iob_uart_poller_pkg;

    // Word addresses of the iob_uart software register bank.
    localparam logic [2:0] DIV_ADDR     = 3'd1;
    localparam logic [2:0] TXDATA_ADDR  = 3'd2;
    localparam logic [2:0] TXEN_ADDR    = 3'd3;
    localparam logic [2:0] RXEN_ADDR    = 3'd4;
    localparam logic [2:0] TXREADY_ADDR = 3'd5;
    localparam logic [2:0] RXREADY_ADDR = 3'd6;
    localparam logic [2:0] RXDATA_ADDR  = 3'd7;

    typedef enum logic [2:0] {
        INIT_DIV,
        INIT_TXEN,
        INIT_RXEN,
        POLL_RX,
        READ_RX,
        POLL_TX,
        WRITE_TX
    } state_t;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/iob_uart_poller_fifo.sv
// Byte FIFO: push lands next cycle, head is combinational from storage.
// Push is taken when not full or when a pop happens in the same cycle; pop of an empty FIFO is ignored.
module iob_uart_poller_fifo
    import iob_uart_poller_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_head_dat = r_mem[r_rd_ptr];

    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/iob_uart_poller.sv
// Configures an iob_uart, then alternately polls RX and TX, moving bytes through two small FIFOs.
// One bus transfer in flight, request registered, idle cycle after each completion; RX stalls when its FIFO is full, tx_ready_o drops when TX is full.
module iob_uart_poller
    import iob_uart_poller_pkg::*;
#(
    parameter int          ADDR_W     = 3,
    parameter int          DATA_W     = 32,
    parameter logic [15:0] BAUD_DIV   = 16'd100,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i,
    output logic [7:0]          rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    input  logic [7:0]          tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic                init_done_o
);

    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_init_done;

    logic                w_done;
    logic                w_rx_push;
    logic                w_rx_pop;
    logic                w_rx_empty;
    logic                w_rx_full;
    logic                w_tx_push;
    logic                w_tx_pop;
    logic                w_tx_empty;
    logic                w_tx_full;
    logic [7:0]          w_tx_head;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic [STRB_W-1:0]   w_req_wstrb;
    logic                w_unused_rdata;

    assign iob_valid_o = r_valid;
    assign iob_addr_o  = r_addr;
    assign iob_wdata_o = r_wdata;
    assign iob_wstrb_o = r_wstrb;
    assign init_done_o = r_init_done;

    assign w_done    = r_valid & iob_ready_i;
    assign w_rx_push = (r_state == READ_RX) & w_done;
    assign w_rx_pop  = rx_valid_o & rx_ready_i;
    assign w_tx_push = tx_valid_i & tx_ready_o;
    assign w_tx_pop  = (r_state == WRITE_TX) & w_done;

    assign rx_valid_o = ~w_rx_empty;
    // Bytes offered before the UART is configured are held off, not buffered.
    assign tx_ready_o = ~w_tx_full & r_init_done;

    assign w_unused_rdata = ^iob_rdata_i[DATA_W-1:8];

    iob_uart_poller_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_rx_push),
        .i_push_dat (iob_rdata_i[7:0]),
        .i_pop      (w_rx_pop),
        .o_head_dat (rx_data_o),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full)
    );

    iob_uart_poller_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_tx_push),
        .i_push_dat (tx_data_i),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full)
    );

    // Request each state would issue; latched only when no transfer is in flight.
    always_comb begin
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_wstrb = '0;
        case (r_state)
            INIT_DIV: begin
                w_req_addr  = ADDR_W'(DIV_ADDR);
                w_req_wdata = DATA_W'(BAUD_DIV);
                w_req_wstrb = STRB_W'(2'b11);
            end
            INIT_TXEN: begin
                w_req_addr  = ADDR_W'(TXEN_ADDR);
                w_req_wdata = DATA_W'(1);
                w_req_wstrb = STRB_W'(1'b1);
            end
            INIT_RXEN: begin
                w_req_addr  = ADDR_W'(RXEN_ADDR);
                w_req_wdata = DATA_W'(1);
                w_req_wstrb = STRB_W'(1'b1);
            end
            POLL_RX:  w_req_addr = ADDR_W'(RXREADY_ADDR);
            READ_RX:  w_req_addr = ADDR_W'(RXDATA_ADDR);
            POLL_TX:  w_req_addr = ADDR_W'(TXREADY_ADDR);
            WRITE_TX: begin
                w_req_addr  = ADDR_W'(TXDATA_ADDR);
                w_req_wdata = DATA_W'(w_tx_head);
                w_req_wstrb = STRB_W'(1'b1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT_DIV;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_init_done <= 1'b0;
        end else if (!r_valid) begin
            if (r_state == POLL_TX && w_tx_empty) begin
                r_state <= POLL_RX;
            end else begin
                r_valid <= 1'b1;
                r_addr  <= w_req_addr;
                r_wdata <= w_req_wdata;
                r_wstrb <= w_req_wstrb;
            end
        end else if (iob_ready_i) begin
            r_valid <= 1'b0;
            r_wstrb <= '0;
            case (r_state)
                INIT_DIV:  r_state <= INIT_TXEN;
                INIT_TXEN: r_state <= INIT_RXEN;
                INIT_RXEN: begin
                    r_state     <= POLL_RX;
                    r_init_done <= 1'b1;
                end
                // RX FIFO can only fill here, so checking it at poll time is safe.
                POLL_RX:   r_state <= (iob_rdata_i[0] && !w_rx_full) ? READ_RX : POLL_TX;
                READ_RX:   r_state <= POLL_TX;
                POLL_TX:   r_state <= iob_rdata_i[0] ? WRITE_TX : POLL_RX;
                WRITE_TX:  r_state <= POLL_RX;
                default:   r_state <= INIT_DIV;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_uart_poller.sv
// Bench for iob_uart_poller: behavioural UART slave, random byte streams and in-order delivery model.
module tb_iob_uart_poller;

    localparam logic [2:0] A_DIV     = 3'd1;
    localparam logic [2:0] A_TXDATA  = 3'd2;
    localparam logic [2:0] A_TXEN    = 3'd3;
    localparam logic [2:0] A_RXEN    = 3'd4;
    localparam logic [2:0] A_TXREADY = 3'd5;
    localparam logic [2:0] A_RXREADY = 3'd6;
    localparam logic [2:0] A_RXDATA  = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        iob_valid_o;
    logic [2:0]  iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic [31:0] iob_rdata_i;
    logic        iob_ready_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        init_done_o;

    always #5 clk = ~clk;

    iob_uart_poller dut (
        .clk         (clk),
        .reset       (reset),
        .iob_valid_o (iob_valid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_rdata_i (iob_rdata_i),
        .iob_ready_i (iob_ready_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .init_done_o (init_done_o)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Virtual UART and stream bookkeeping
    logic [7:0]  rx_src[$];
    logic [7:0]  rx_got[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  tx_src[$];
    logic [7:0]  tx_gen[$];
    logic [31:0] tx_wdata[$];
    logic [3:0]  tx_wstrb[$];
    txn_t        txn_log[$];
    bit          stall;
    bit          uart_txready;
    int          lat_min;
    int          lat_max;
    int          rx_mode;
    int          rx_valid_cycles;
    int          n_rxdata_reads;
    int          n_rxready_reads;
    logic [2:0]  last_addr;

    // Slave state
    int          s_cnt;
    int          s_lat;
    bit          s_pv;
    bit          s_pr;
    logic [2:0]  s_pa;
    logic [31:0] s_pd;
    logic [3:0]  s_ps;
    logic [31:0] s_rnd;
    bit          tx_pend;

    // Scratch for the directed sequence
    logic [7:0]  b;
    logic [7:0]  burst[$];
    int          snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus slave: random ready latency, protocol checks, register semantics.
    initial begin
        iob_ready_i = 1'b0;
        iob_rdata_i = '0;
        s_cnt = 0; s_lat = 2; s_pv = 0; s_pr = 0; last_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                iob_ready_i = 1'b0;
                s_cnt = 0; s_pv = 0; s_pr = 0; last_addr = '0;
            end else begin
                if (s_pv && s_pr) begin
                    check("valid_drop_after_ready", iob_valid_o, 0);
                end else if (s_pv) begin
                    check("valid_held", iob_valid_o, 1);
                    check("addr_held", iob_addr_o, s_pa);
                    check("wdata_held", iob_wdata_o, s_pd);
                    check("wstrb_held", iob_wstrb_o, s_ps);
                end
                s_pv = iob_valid_o; s_pa = iob_addr_o; s_pd = iob_wdata_o; s_ps = iob_wstrb_o;
                if (iob_ready_i) begin
                    iob_ready_i = 1'b0;
                end else if (iob_valid_o && !stall) begin
                    s_cnt++;
                    if (s_cnt >= s_lat) begin
                        s_cnt = 0;
                        s_lat = $urandom_range(lat_min, lat_max);
                        s_rnd = $urandom;
                        iob_rdata_i = s_rnd;
                        case (iob_addr_o)
                            A_RXREADY: begin
                                iob_rdata_i = {s_rnd[31:1], (rx_src.size() > 0)};
                                n_rxready_reads++;
                            end
                            A_RXDATA: begin
                                check("rxdata_after_rxready", last_addr, A_RXREADY);
                                check("rxdata_byte_available", rx_src.size() > 0, 1);
                                if (rx_src.size() > 0) iob_rdata_i = {s_rnd[31:8], rx_src.pop_front()};
                                n_rxdata_reads++;
                            end
                            A_TXREADY: begin
                                check("txpoll_after_rxpoll", (last_addr == A_RXREADY) || (last_addr == A_RXDATA), 1);
                                iob_rdata_i = {s_rnd[31:1], uart_txready};
                            end
                            A_TXDATA: begin
                                check("txdata_after_txready", last_addr, A_TXREADY);
                                tx_wdata.push_back(iob_wdata_o);
                                tx_wstrb.push_back(iob_wstrb_o);
                            end
                            default: ;
                        endcase
                        txn_log.push_back('{iob_addr_o, iob_wdata_o, iob_wstrb_o});
                        last_addr = iob_addr_o;
                        iob_ready_i = 1'b1;
                    end
                end
                s_pr = iob_ready_i;
            end
        end
    end

    // RX consumer
    initial begin
        rx_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_mode == 0)      rx_ready_i = 1'b0;
            else if (rx_mode == 1) rx_ready_i = 1'b1;
            else                   rx_ready_i = 1'($urandom_range(0, 1));
            if (!reset && rx_valid_o) begin
                rx_valid_cycles++;
                if (rx_ready_i) rx_got.push_back(rx_data_o);
            end
        end
    end

    // TX producer: holds each byte until accepted
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        tx_pend    = 0;
        forever begin
            @(negedge clk);
            if (reset) tx_pend = 0;
            if (tx_pend) begin
                void'(tx_src.pop_front());
                tx_pend = 0;
            end
            tx_valid_i = (tx_src.size() > 0);
            tx_data_i  = (tx_src.size() > 0) ? tx_src[0] : 8'($urandom);
            tx_pend    = tx_valid_i && tx_ready_o;
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx_mode = 1; uart_txready = 1; stall = 0; lat_min = 2; lat_max = 2;
        rx_valid_cycles = 0; n_rxdata_reads = 0; n_rxready_reads = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", iob_valid_o, 0);
        check("rst_wstrb", iob_wstrb_o, 0);
        check("rst_addr", iob_addr_o, 0);
        check("rst_wdata", iob_wdata_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_tx_ready", tx_ready_o, 0);
        check("rst_init_done", init_done_o, 0);

        // Init sequence; a TX byte is offered early and must be held off
        tx_src.push_back(8'h99);
        reset = 1'b0;
        @(negedge clk); #1;
        check("init_first_valid", iob_valid_o, 1);
        check("init_first_addr", iob_addr_o, A_DIV);
        for (int i = 0; i < 40 && txn_log.size() < 3; i++) begin
            check("tx_ready_before_init", tx_ready_o, 0);
            check("init_done_early", init_done_o, 0);
            @(negedge clk); #1;
        end
        check("init_txn_count", txn_log.size(), 3);
        if (txn_log.size() >= 3) begin
            check("init0_addr", txn_log[0].addr, A_DIV);
            check("init0_wdata", txn_log[0].wdata, 32'h64);
            check("init0_wstrb", txn_log[0].wstrb, 4'b0011);
            check("init1_addr", txn_log[1].addr, A_TXEN);
            check("init1_wdata", txn_log[1].wdata, 1);
            check("init1_wstrb", txn_log[1].wstrb, 4'b0001);
            check("init2_addr", txn_log[2].addr, A_RXEN);
            check("init2_wdata", txn_log[2].wdata, 1);
            check("init2_wstrb", txn_log[2].wstrb, 4'b0001);
        end
        check("init_done_in_ready_cycle", init_done_o, 0);
        @(negedge clk); #1;
        check("init_done_after_ready", init_done_o, 1);
        check("tx_ready_after_init", tx_ready_o, 1);

        // Two RX bytes, consumer always ready
        rx_valid_cycles = 0;
        rx_src.push_back(8'h41);
        rx_src.push_back(8'h42);
        for (int i = 0; i < 300 && rx_got.size() < 2; i++) @(negedge clk);
        #1;
        check("rx2_count", rx_got.size(), 2);
        if (rx_got.size() >= 2) begin
            check("rx2_byte0", rx_got[0], 8'h41);
            check("rx2_byte1", rx_got[1], 8'h42);
        end
        repeat (10) @(negedge clk);
        #1;
        check("rx2_valid_cycles", rx_valid_cycles, 2);
        check("early_tx_count", tx_wdata.size(), 1);
        if (tx_wdata.size() >= 1) check("early_tx_byte", tx_wdata[0], 32'h99);

        // Two TX bytes
        tx_wdata.delete(); tx_wstrb.delete();
        tx_src.push_back(8'h55);
        tx_src.push_back(8'hAA);
        for (int i = 0; i < 300 && tx_wdata.size() < 2; i++) @(negedge clk);
        #1;
        check("tx2_count", tx_wdata.size(), 2);
        if (tx_wdata.size() >= 2) begin
            check("tx2_wdata0", tx_wdata[0], 32'h0000_0055);
            check("tx2_wdata1", tx_wdata[1], 32'h0000_00AA);
            check("tx2_wstrb0", tx_wstrb[0], 4'b0001);
            check("tx2_wstrb1", tx_wstrb[1], 4'b0001);
        end

        // RX backpressure: FIFO fills to 4, then only polls
        rx_mode = 0; rx_got.delete(); n_rxdata_reads = 0; burst.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            burst.push_back(b);
            rx_src.push_back(b);
        end
        repeat (150) @(negedge clk);
        #1;
        check("rxbp_reads", n_rxdata_reads, 4);
        check("rxbp_left_in_uart", rx_src.size(), 4);
        check("rxbp_valid", rx_valid_o, 1);
        snap = n_rxready_reads;
        repeat (40) @(negedge clk);
        #1;
        check("rxbp_polls_continue", (n_rxready_reads - snap) > 0, 1);
        check("rxbp_no_more_reads", n_rxdata_reads, 4);
        rx_mode = 1;
        for (int i = 0; i < 400 && rx_got.size() < 8; i++) @(negedge clk);
        #1;
        check("rxbp_drained", rx_got.size(), 8);
        for (int i = 0; i < 8 && i < rx_got.size(); i++) check("rxbp_order", rx_got[i], burst[i]);

        // TX backpressure: UART not ready, 4 bytes queued fill the FIFO
        uart_txready = 0; tx_wdata.delete(); tx_wstrb.delete(); burst.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            burst.push_back(b);
            tx_src.push_back(b);
        end
        repeat (50) @(negedge clk);
        #1;
        check("txbp_ready_low", tx_ready_o, 0);
        check("txbp_no_writes", tx_wdata.size(), 0);
        uart_txready = 1;
        for (int i = 0; i < 400 && tx_wdata.size() < 4; i++) @(negedge clk);
        #1;
        check("txbp_written", tx_wdata.size(), 4);
        for (int i = 0; i < 4 && i < tx_wdata.size(); i++) check("txbp_order", tx_wdata[i], {24'h0, burst[i]});

        // Random traffic in both directions
        rx_got.delete(); tx_wdata.delete(); tx_wstrb.delete(); rx_exp.delete(); tx_gen.delete();
        lat_min = 1; lat_max = 3; rx_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            uart_txready = ($urandom_range(0, 3) != 0);
            if (rx_exp.size() < 40 && $urandom_range(0, 9) == 0) begin
                b = 8'($urandom);
                rx_exp.push_back(b);
                rx_src.push_back(b);
            end
            if (tx_gen.size() < 40 && $urandom_range(0, 9) == 0) begin
                b = 8'($urandom);
                tx_gen.push_back(b);
                tx_src.push_back(b);
            end
        end
        uart_txready = 1; rx_mode = 1;
        for (int i = 0; i < 3000 && (rx_got.size() < rx_exp.size() || tx_wdata.size() < tx_gen.size()); i++)
            @(negedge clk);
        repeat (20) @(negedge clk);
        #1;
        check("rand_rx_count", rx_got.size(), rx_exp.size());
        check("rand_tx_count", tx_wdata.size(), tx_gen.size());
        for (int i = 0; i < rx_exp.size() && i < rx_got.size(); i++) check("rand_rx_byte", rx_got[i], rx_exp[i]);
        for (int i = 0; i < tx_gen.size() && i < tx_wdata.size(); i++) begin
            check("rand_tx_wdata", tx_wdata[i], {24'h0, tx_gen[i]});
            check("rand_tx_wstrb", tx_wstrb[i], 4'b0001);
        end

        // Reset in the middle of a stalled transfer with both FIFOs holding data
        lat_min = 2; lat_max = 2; rx_mode = 0; uart_txready = 0;
        rx_src.push_back(8'h11); rx_src.push_back(8'h22);
        tx_src.push_back(8'h33); tx_src.push_back(8'h44);
        repeat (80) @(negedge clk);
        #1;
        check("mid_rx_fifo_has_data", rx_valid_o, 1);
        stall = 1;
        for (int i = 0; i < 20 && !iob_valid_o; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
        check("mid_valid_stalled", iob_valid_o, 1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_valid", iob_valid_o, 0);
        check("mid_rst_wstrb", iob_wstrb_o, 0);
        check("mid_rst_addr", iob_addr_o, 0);
        check("mid_rst_wdata", iob_wdata_o, 0);
        check("mid_rst_rx_valid", rx_valid_o, 0);
        check("mid_rst_tx_ready", tx_ready_o, 0);
        check("mid_rst_init_done", init_done_o, 0);
        rx_src.delete(); tx_src.delete(); txn_log.delete(); rx_got.delete();
        tx_wdata.delete(); tx_wstrb.delete();
        stall = 0; uart_txready = 1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("restart_valid", iob_valid_o, 1);
        check("restart_addr", iob_addr_o, A_DIV);
        check("restart_wdata", iob_wdata_o, 32'h64);
        check("restart_wstrb", iob_wstrb_o, 4'b0011);
        repeat (60) @(negedge clk);
        #1;
        check("restart_init_done", init_done_o, 1);
        check("restart_rx_empty", rx_valid_o, 0);
        check("restart_tx_ready", tx_ready_o, 1);
        check("restart_tx_empty", tx_wdata.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
